// File: rtl/fir4_tap_mac.sv
// fir4_tap_mac: 4-tap FIR multiply-accumulate, one shared multiplier over four MAC cycles.
// Build option: FIR4_SAT_EN selects output saturation instead of two's-complement wrap.
`default_nettype none

module fir4_tap_mac #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACCW  = 34,
  parameter int OW    = 16,
  parameter int SHIFT = 15
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] tap1,
  input  logic signed [DW-1:0] tap2,
  input  logic signed [DW-1:0] tap3,
  input  logic signed [DW-1:0] tap4,
  input  logic                 coef_we,
  input  logic [1:0]           coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        dout,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic signed [DW-1:0]    tap_q  [4];
  logic signed [CW-1:0]    coef_q [4];
  logic signed [ACCW-1:0]  acc;
  logic signed [ACCW-1:0]  sum;
  logic signed [DW+CW-1:0] prod;
  logic [1:0]              idx;
  logic [OW-1:0]           res;
  logic                    accept;
  logic                    out_fire;

  assign in_ready = (state == IDLE);
  assign busy     = (state == MAC) || (state == OUT);
  assign accept   = in_valid && (state == IDLE);
  assign out_fire = out_valid && out_ready;

  assign prod = tap_q[idx] * coef_q[idx];
  assign sum  = acc + {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};

`ifdef FIR4_SAT_EN
  // Shifted result fits in OW bits only if all bits above its sign bit match it.
  logic [ACCW-SHIFT-OW:0] top;
  logic                   ovf;
  assign top = sum[ACCW-1:SHIFT+OW-1];
  assign ovf = (top != '0) && (top != '1);
  assign res = ovf ? (sum[ACCW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}})
                   : sum[SHIFT+OW-1:SHIFT];
`else
  assign res = sum[SHIFT+OW-1:SHIFT];
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = MAC;
      MAC:     if (idx == 2'd3) state_nx = OUT;
      OUT:     if (out_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < 4; k++) begin
        tap_q[k]  <= '0;
        coef_q[k] <= '0;
      end
      acc       <= '0;
      idx       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      // Coefficients are only writable between samples; the MAC reads them from the next edge on.
      if (state == IDLE && coef_we) coef_q[coef_addr] <= coef_wdata;
      case (state)
        IDLE: begin
          if (accept) begin
            tap_q[0] <= tap1;
            tap_q[1] <= tap2;
            tap_q[2] <= tap3;
            tap_q[3] <= tap4;
            acc      <= '0;
            idx      <= '0;
          end
        end
        MAC: begin
          acc <= sum;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            dout      <= res;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_fire) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir4_tap_mac.sv
// Self-checking bench for fir4_tap_mac: directed cases plus randomized samples vs. an arithmetic model.
`default_nettype none

module tb_fir4_tap_mac;

  logic               CLK = 1'b0;
  logic               Reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] tap1, tap2, tap3, tap4;
  logic               coef_we;
  logic [1:0]         coef_addr;
  logic signed [15:0] coef_wdata;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        dout;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [15:0] mcoef [4];

  fir4_tap_mac dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tap1       (tap1),
    .tap2       (tap2),
    .tap3       (tap3),
    .tap4       (tap4),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout       (dout),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // y = floor(sum(tap*coef) / 2^15), then clamped or wrapped to 16 bits
  function automatic logic [15:0] model(input logic signed [15:0] a, b, c, d);
    longint s;
    logic [63:0] r;
    s = longint'(a) * longint'(mcoef[0]) + longint'(b) * longint'(mcoef[1])
      + longint'(c) * longint'(mcoef[2]) + longint'(d) * longint'(mcoef[3]);
    s = s >>> 15;
`ifdef FIR4_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    r = s;
    return r[15:0];
  endfunction

  task automatic write_coef(input logic [1:0] a, input logic signed [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(posedge CLK); #1;
    coef_we = 1'b0;
    mcoef[a] = d;
  endtask

  task automatic run_sample(input logic signed [15:0] a, b, c, d, input int stall,
                            input bit wr, input logic [1:0] wa, input logic signed [15:0] wd,
                            input bit mac_wr, input string tag);
    logic [15:0] exp;
    int lat;
    tap1 = a; tap2 = b; tap3 = c; tap4 = d;
    in_valid = 1'b1;
    if (wr) begin
      coef_we = 1'b1; coef_addr = wa; coef_wdata = wd;
      mcoef[wa] = wd;
    end
    exp = model(a, b, c, d);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    chk({tag, "_busy_mac"}, busy, 1);
    chk({tag, "_in_ready_mac"}, in_ready, 0);
    if (mac_wr) begin
      coef_we = 1'b1; coef_addr = 2'd2; coef_wdata = 16'h1234;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge CLK); #1;
      coef_we = 1'b0;
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_dout"}, dout, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge CLK); #1;
      chk({tag, "_stall_dout"}, dout, exp);
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_in_ready"}, in_ready, 0);
      chk({tag, "_stall_busy"}, busy, 1);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
    chk({tag, "_busy_done"}, busy, 0);
  endtask

  logic signed [15:0] ts [3][4];
  logic [15:0]        texp [3];

  initial begin
    Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; coef_we = 1'b0;
    coef_addr = '0; coef_wdata = '0; tap1 = '0; tap2 = '0; tap3 = '0; tap4 = '0;
    for (int k = 0; k < 4; k++) mcoef[k] = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    Reset = 1'b1;
    @(posedge CLK); #1;
    chk("rst_in_ready", in_ready, 1);

    // T1: half-scale coefficients
    for (int k = 0; k < 4; k++) write_coef(2'(k), 16'sh4000);
    run_sample(16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000, 0, 0, 0, 0, 0, "t1");
    chk("t1_const", dout, 16'd5000);

    // T2: full-scale overflow of the output range, with T3's 10-cycle stall
    for (int k = 0; k < 4; k++) write_coef(2'(k), 16'sh7FFF);
    run_sample(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 10, 0, 0, 0, 0, "t2");

    // T4: a write during MAC is dropped
    for (int k = 0; k < 4; k++) write_coef(2'(k), (k == 2) ? 16'sh0000 : 16'sh4000);
    run_sample(16'sd7, 16'sd11, 16'sd13, 16'sd17, 0, 0, 0, 0, 1, "t4a");
    run_sample(16'sd100, 16'sd200, 16'sd300, 16'sd400, 0, 0, 0, 0, 0, "t4b");
    chk("t4_const", dout, 16'd350);

    // Write on the accept edge is used by that sample
    run_sample(16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000, 1, 1, 2'd2, 16'sh7FFF, 0, "acc_wr");

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) write_coef(2'($urandom_range(0, 3)), 16'($urandom));
      run_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 16'($urandom), 0, "rnd");
    end

    // T5: reset in the 2nd MAC cycle
    for (int k = 0; k < 4; k++) write_coef(2'(k), 16'sh4000);
    run_sample(16'sd100, 16'sd200, 16'sd300, 16'sd400, 0, 0, 0, 0, 0, "t5pre");
    tap1 = 16'sd500; tap2 = 16'sd600; tap3 = 16'sd700; tap4 = 16'sd800;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_dout", dout, 0);
    chk("t5_busy", busy, 0);
    @(posedge CLK); #1;
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) mcoef[k] = '0;
    @(posedge CLK); #1;
    chk("t5_in_ready", in_ready, 1);
    run_sample(16'sd1234, -16'sd4321, 16'sd999, 16'sd32000, 0, 0, 0, 0, 0, "t5post");

    // T6: back-to-back samples with out_ready held high
    for (int k = 0; k < 4; k++) write_coef(2'(k), 16'($urandom));
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) ts[s][k] = 16'($urandom);
      texp[s] = model(ts[s][0], ts[s][1], ts[s][2], ts[s][3]);
    end
    begin
      int nacc, nout, last;
      bit acc_now;
      nacc = 0; nout = 0; last = 0;
      tap1 = ts[0][0]; tap2 = ts[0][1]; tap3 = ts[0][2]; tap4 = ts[0][3];
      in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && nout < 3; cyc++) begin
        acc_now = in_ready && in_valid;
        @(posedge CLK); #1;
        if (acc_now) begin
          nacc++;
          if (nacc < 3) begin
            tap1 = ts[nacc][0]; tap2 = ts[nacc][1]; tap3 = ts[nacc][2]; tap4 = ts[nacc][3];
          end else in_valid = 1'b0;
        end
        if (out_valid) begin
          chk("t6_dout", dout, texp[nout]);
          if (nout > 0) chk("t6_spacing", cyc - last, 6);
          last = cyc;
          nout++;
        end
      end
      chk("t6_count", nout, 3);
      in_valid = 1'b0; out_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
